// File: rtl/tt_um_delay_meter.sv
`default_nettype none
// ============================================================================
// Module   : tt_um_delay_meter
// Brief    : Measures loop delay in whole clk cycles through an inverter-chain
//            tap, or an external uio[0] pad loop when DELAY_METER_EXT_LOOP_EN
//            is defined. Optional 2^AVG_LOG2-run averaging, byte-wise readout.
// Revision : 1.0 - initial release
// ============================================================================
module tt_um_delay_meter #(
    parameter logic [23:0] MAX_COUNT    = 24'd10_000_000,
    parameter int          CHAIN_STAGES = 64,
    parameter int          CNT_W        = 16,
    parameter int          AVG_LOG2     = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    output logic [7:0] uo_out,
    input  logic [7:0] uio_in,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);
    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LAUNCH = 2'd1,
        S_WAIT   = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    localparam int          ACC_W    = CNT_W + AVG_LOG2;
    localparam logic [3:0]  LAST_RUN = 4'((1 << AVG_LOG2) - 1);
    localparam logic [23:0] TMO_LAST = MAX_COUNT - 24'd1;

    state_t           state, state_nx;
    logic [1:0]       start_sync;
    logic             start_d, start_edge;
    logic [1:0]       ret_sync;
    logic             ret_s, ret_raw;
    logic             launch, done, timeout, avg_latched, busy;
    logic [1:0]       tap_sel;
    logic [3:0]       run_idx;
    logic [CNT_W-1:0] cnt, run_val, result;
    logic [23:0]      tmo_cnt;
    logic [ACC_W-1:0] accum, accum_sum;
    logic             match, tmo_hit, last_run;
    logic [15:0]      result16;
    logic             unused_ok;

`ifdef DELAY_METER_EXT_LOOP_EN
    assign ret_raw   = uio_in[0];
    assign uio_out   = {7'b0, launch};
    assign uio_oe    = 8'h01;
    assign unused_ok = &{1'b0, ui_in[7:6], tap_sel, uio_in[7:1]};
`else
    logic       chain [0:CHAIN_STAGES];
    logic [3:0] taps;

    assign chain[0] = launch;
    for (genvar i = 0; i < CHAIN_STAGES; i++) begin : g_chain
        assign chain[i+1] = ~chain[i];
    end
    // Every tap sits on a multiple of CHAIN_STAGES/4 (even) stages: non-inverting.
    for (genvar k = 0; k < 4; k++) begin : g_tap
        assign taps[k] = chain[CHAIN_STAGES*(k+1)/4];
    end

    assign ret_raw   = taps[tap_sel];
    assign uio_out   = 8'h00;
    assign uio_oe    = 8'h00;
    assign unused_ok = &{1'b0, ui_in[7:6], uio_in};
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            start_sync <= 2'b00;
            start_d    <= 1'b0;
            ret_sync   <= 2'b00;
        end else begin
            start_sync <= {start_sync[0], ui_in[0]};
            start_d    <= start_sync[1];
            ret_sync   <= {ret_sync[0], ret_raw};
        end
    end

    assign start_edge = start_sync[1] & ~start_d;
    assign ret_s      = ret_sync[1];
    assign match      = (ret_s == launch);
    assign tmo_hit    = (tmo_cnt == TMO_LAST);
    assign last_run   = (run_idx == LAST_RUN);
    assign run_val    = (&cnt) ? cnt : cnt + 1'b1;
    assign accum_sum  = accum + ACC_W'(run_val);
    assign busy       = (state == S_LAUNCH) || (state == S_WAIT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE, S_DONE: if (start_edge) state_nx = S_LAUNCH;
            S_LAUNCH:       state_nx = S_WAIT;
            S_WAIT: begin
                if (match)        state_nx = (avg_latched && !last_run) ? S_LAUNCH : S_DONE;
                else if (tmo_hit) state_nx = S_DONE;
            end
            default:        state_nx = S_IDLE;
        endcase
        if (!ena) state_nx = S_IDLE;
    end

    // Launch flips on entry to LAUNCH so the LAUNCH cycle already fills the
    // first synchroniser stage; a zero-delay loop then reads back as 2.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            launch      <= 1'b0;
            tap_sel     <= 2'b00;
            avg_latched <= 1'b0;
            accum       <= '0;
            run_idx     <= 4'd0;
            done        <= 1'b0;
            timeout     <= 1'b0;
            cnt         <= '0;
            tmo_cnt     <= 24'd0;
            result      <= '0;
        end else begin
            if (state_nx == S_LAUNCH) launch <= ~launch;
            if ((state == S_IDLE || state == S_DONE) && state_nx == S_LAUNCH) begin
                tap_sel     <= ui_in[2:1];
                avg_latched <= ui_in[3];
                accum       <= '0;
                run_idx     <= 4'd0;
                done        <= 1'b0;
                timeout     <= 1'b0;
            end
            if (state == S_LAUNCH) begin
                cnt     <= '0;
                tmo_cnt <= 24'd0;
            end
            if (state == S_WAIT && ena) begin
                if (!(&cnt)) cnt <= cnt + 1'b1;
                tmo_cnt <= tmo_cnt + 24'd1;
                if (match) begin
                    if (avg_latched) begin
                        accum <= accum_sum;
                        if (last_run) begin
                            result <= accum_sum[ACC_W-1:AVG_LOG2];
                            done   <= 1'b1;
                        end else begin
                            run_idx <= run_idx + 4'd1;
                        end
                    end else begin
                        result <= run_val;
                        done   <= 1'b1;
                    end
                end else if (tmo_hit) begin
                    result  <= '1;
                    timeout <= 1'b1;
                    done    <= 1'b1;
                end
            end
        end
    end

    assign result16 = 16'(result);

    always_comb begin
        case (ui_in[5:4])
            2'd0:    uo_out = result16[7:0];
            2'd1:    uo_out = result16[15:8];
            2'd2:    uo_out = {busy, done, timeout, avg_latched, run_idx};
            default: uo_out = {6'b0, launch, ret_s};
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_tt_um_delay_meter.sv
`default_nettype none
// Bench for tt_um_delay_meter: table of single/averaged runs plus hand-written
// sequences for busy-start, ena abort, async reset and timeout.
module tb_tt_um_delay_meter;
`ifdef DELAY_METER_EXT_LOOP_EN
    localparam bit          EXT   = 1'b1;
    localparam logic [23:0] T_MAX = 24'd100;
    localparam int          T_CW  = 16;
`else
    localparam bit          EXT   = 1'b0;
    localparam logic [23:0] T_MAX = 24'd1;
    localparam int          T_CW  = 8;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ena = 1'b1;
    logic [7:0] ui_in = 8'h00, ui_in2 = 8'h00;
    logic [7:0] uo_out, uo_out2, uio_in, uio_out, uio_oe, uio_out2, uio_oe2;
    logic [7:0] uio_in2 = 8'h00;

    int nchecks = 0;
    int nerrors = 0;

    // External loop model: uio_out[0] fed back after dly whole cycles, or
    // alternating 3/5 cycles per launch toggle when alt is set.
    logic [7:0] sh = 8'h00;
    int ntog = 0, tog_base = 0, dly = 0;
    bit alt = 1'b0;

    always @(posedge clk) sh <= {sh[6:0], uio_out[0]};
    always @(uio_out[0]) ntog++;
    always_comb begin
        int d;
        d = alt ? ((((ntog - tog_base) % 2) == 1) ? 3 : 5) : dly;
        uio_in = 8'h00;
        uio_in[0] = (d == 0) ? uio_out[0] : sh[d-1];
    end

    always #5 clk = ~clk;

    tt_um_delay_meter dut (
        .clk(clk), .rst_n(rst_n), .ena(ena), .ui_in(ui_in), .uo_out(uo_out),
        .uio_in(uio_in), .uio_out(uio_out), .uio_oe(uio_oe)
    );

    tt_um_delay_meter #(.MAX_COUNT(T_MAX), .CNT_W(T_CW)) dut2 (
        .clk(clk), .rst_n(rst_n), .ena(ena), .ui_in(ui_in2), .uo_out(uo_out2),
        .uio_in(uio_in2), .uio_out(uio_out2), .uio_oe(uio_oe2)
    );

    typedef struct {
        bit          avg;
        logic [1:0]  tap;
        bit          alt;
        int          dly;
        logic [15:0] res;
        logic [7:0]  stat;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        nchecks++;
        if (act !== exp) begin
            nerrors++;
            $display("FAIL %s: got %02h expected %02h", name, act, exp);
        end
    endtask

    task automatic set_sel(input logic [1:0] s);
        ui_in[5:4]  = s;
        ui_in2[5:4] = s;
    endtask

    task automatic chk_sel(input bit which, input logic [1:0] s, input logic [7:0] exp,
                           input string name);
        set_sel(s);
        #1;
        chk(name, which ? uo_out2 : uo_out, exp);
    endtask

    task automatic pulse_start(input bit which, input bit avg, input logic [1:0] tap);
        @(negedge clk);
        if (which) ui_in2[3:0] = {avg, tap, 1'b1};
        else       ui_in[3:0]  = {avg, tap, 1'b1};
        repeat (3) @(negedge clk);
        if (which) ui_in2[0] = 1'b0;
        else       ui_in[0]  = 1'b0;
    endtask

    task automatic wait_done(input bit which, input string name, output int cyc);
        bit ok;
        ok  = 1'b0;
        cyc = 0;
        set_sel(2'd2);
        for (int i = 1; i <= 3000 && !ok; i++) begin
            @(negedge clk);
            #1;
            if ((which ? uo_out2[7:6] : uo_out[7:6]) == 2'b01) begin
                ok  = 1'b1;
                cyc = i;
            end
        end
        nchecks++;
        if (!ok) begin
            nerrors++;
            $display("FAIL %s wait_done: got no done within 3000 cycles, expected done", name);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got simulation still running, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit          launch_exp;
        int          cyc;
        logic [7:0]  seq_res, seq_stat, oe_exp;
        bit          seq_avg;

        seq_avg  = !EXT;
        seq_res  = EXT ? 8'h07 : 8'h02;
        seq_stat = EXT ? 8'h40 : 8'h57;
        oe_exp   = EXT ? 8'h01 : 8'h00;

        if (EXT) begin
            vecs[0] = '{1'b0, 2'd0, 1'b0, 0, 16'd2, 8'h40};
            vecs[1] = '{1'b0, 2'd0, 1'b0, 5, 16'd7, 8'h40};
            vecs[2] = '{1'b1, 2'd0, 1'b1, 0, 16'd6, 8'h57};
            vecs[3] = '{1'b0, 2'd3, 1'b0, 1, 16'd3, 8'h40};
            vecs[4] = '{1'b1, 2'd0, 1'b0, 2, 16'd4, 8'h57};
            vecs[5] = '{1'b0, 2'd0, 1'b0, 3, 16'd5, 8'h40};
            vecs[6] = '{1'b1, 2'd1, 1'b0, 0, 16'd2, 8'h57};
            vecs[7] = '{1'b0, 2'd2, 1'b0, 7, 16'd9, 8'h40};
        end else begin
            vecs[0] = '{1'b0, 2'd0, 1'b0, 0, 16'd2, 8'h40};
            vecs[1] = '{1'b0, 2'd1, 1'b0, 0, 16'd2, 8'h40};
            vecs[2] = '{1'b0, 2'd2, 1'b0, 0, 16'd2, 8'h40};
            vecs[3] = '{1'b0, 2'd3, 1'b0, 0, 16'd2, 8'h40};
            vecs[4] = '{1'b1, 2'd0, 1'b0, 0, 16'd2, 8'h57};
            vecs[5] = '{1'b1, 2'd1, 1'b0, 0, 16'd2, 8'h57};
            vecs[6] = '{1'b1, 2'd2, 1'b0, 0, 16'd2, 8'h57};
            vecs[7] = '{1'b1, 2'd3, 1'b0, 0, 16'd2, 8'h57};
        end

        // Reset state
        repeat (3) @(negedge clk);
        chk_sel(0, 2'd0, 8'h00, "reset res_lo");
        chk_sel(0, 2'd1, 8'h00, "reset res_hi");
        chk_sel(0, 2'd2, 8'h00, "reset status");
        chk_sel(0, 2'd3, 8'h00, "reset launch_ret");
        chk("reset uio_out", uio_out, 8'h00);
        chk("reset uio_oe", uio_oe, oe_exp);
        @(negedge clk);
        rst_n = 1'b1;
        launch_exp = 1'b0;

        foreach (vecs[i]) begin
            dly = vecs[i].dly;
            alt = vecs[i].alt;
            tog_base = ntog;
            repeat (10) @(negedge clk);
            pulse_start(0, vecs[i].avg, vecs[i].tap);
            wait_done(0, $sformatf("vec%0d", i), cyc);
            if (!vecs[i].avg) launch_exp = ~launch_exp;
            chk_sel(0, 2'd0, vecs[i].res[7:0],  $sformatf("vec%0d res_lo", i));
            chk_sel(0, 2'd1, vecs[i].res[15:8], $sformatf("vec%0d res_hi", i));
            chk_sel(0, 2'd2, vecs[i].stat,      $sformatf("vec%0d status", i));
            chk_sel(0, 2'd3, {6'b0, launch_exp, launch_exp}, $sformatf("vec%0d launch_ret", i));
            chk($sformatf("vec%0d uio_out", i), uio_out, EXT ? {7'b0, launch_exp} : 8'h00);
            chk($sformatf("vec%0d uio_oe", i), uio_oe, oe_exp);
        end

        // Second start while busy is ignored
        dly = 5;
        alt = 1'b0;
        repeat (10) @(negedge clk);
        pulse_start(0, seq_avg, 2'd0);
        set_sel(2'd2);
        #1;
        chk("busy after start", {7'b0, uo_out[7]}, 8'h01);
        pulse_start(0, seq_avg, 2'd0);
        wait_done(0, "busy_start", cyc);
        if (!seq_avg) launch_exp = ~launch_exp;
        chk_sel(0, 2'd0, seq_res,  "busy_start res_lo");
        chk_sel(0, 2'd2, seq_stat, "busy_start status");
        chk_sel(0, 2'd3, {6'b0, launch_exp, launch_exp}, "busy_start launch_ret");

        // ena low mid-run: busy clears, result holds, FSM stays idle
        repeat (10) @(negedge clk);
        pulse_start(0, seq_avg, 2'd0);
        repeat (3) @(negedge clk);
        ena = 1'b0;
        repeat (2) @(negedge clk);
        set_sel(2'd2);
        #1;
        chk("ena_off busy_done", {6'b0, uo_out[7:6]}, 8'h00);
        chk_sel(0, 2'd0, seq_res, "ena_off res_hold");
        repeat (5) @(negedge clk);
        set_sel(2'd2);
        #1;
        chk("ena_off stays idle", {7'b0, uo_out[7]}, 8'h00);
        ena = 1'b1;
        repeat (10) @(negedge clk);
        tog_base = ntog;
        pulse_start(0, seq_avg, 2'd0);
        wait_done(0, "ena_rerun", cyc);
        chk_sel(0, 2'd0, seq_res,  "ena_rerun res_lo");
        chk_sel(0, 2'd2, seq_stat, "ena_rerun status");

        // Async reset mid-WAIT
        repeat (10) @(negedge clk);
        pulse_start(0, seq_avg, 2'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        chk_sel(0, 2'd0, 8'h00, "midreset res_lo");
        chk_sel(0, 2'd2, 8'h00, "midreset status");
        chk_sel(0, 2'd3, 8'h00, "midreset launch_ret");
        chk("midreset uio_out", uio_out, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;

        // Timeout on the second instance (loop held at 0 / MAX_COUNT=1)
        repeat (3) @(negedge clk);
        pulse_start(1, 1'b0, 2'd0);
        wait_done(1, "timeout", cyc);
        chk("timeout latency", 8'(cyc), EXT ? 8'd101 : 8'd2);
        chk_sel(1, 2'd0, 8'hFF, "timeout res_lo");
        chk_sel(1, 2'd1, EXT ? 8'hFF : 8'h00, "timeout res_hi");
        chk_sel(1, 2'd2, 8'h60, "timeout status");
        chk_sel(1, 2'd3, EXT ? 8'h02 : 8'h03, "timeout launch_ret");
        chk("timeout uio_oe", uio_oe2, oe_exp);

        $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/tt_um_delay_meter.md
Name: tt_um_delay_meter

Overview:
- Tiny Tapeout user tile that measures loop delay in whole clock cycles.
- Toggles a launch bit, sends it through a selectable inverter-chain tap (or an external pad loop), and counts clk cycles until the synchronised return matches.
- Optionally averages 2^AVG_LOG2 runs; results are read out byte-wise on uo_out.
- Successor to the single-inverter clock tile: parametrised chain length, timeout, averaging, readout.

Parameters:
- MAX_COUNT, 24'd10_000_000: timeout in clk cycles per run.
- CHAIN_STAGES, 64: inverter count in the internal chain; must be a multiple of 8. Taps are at CHAIN_STAGES*(k+1)/4, k=0..3, so every tap is non-inverting.
- CNT_W, 16: run counter width, legal range 8..16. Result bits above CNT_W read 0.
- AVG_LOG2, 3: log2 of the number of runs averaged in averaging mode, legal range 1..4.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- ena  in  1  tile enable
- ui_in  in  8  [0] start, [2:1] tap select, [3] avg mode, [5:4] readout byte select, [7:6] unused
- uo_out  out  8  readout byte
- uio_in  in  8  [0] external return (EXT_LOOP_EN only); otherwise unused
- uio_out  out  8  [0] launch bit (EXT_LOOP_EN only); otherwise 8'h00
- uio_oe  out  8  8'h00, or 8'h01 with EXT_LOOP_EN

Behaviour:
- Reset (rst_n low, async): state IDLE; launch=0; counters, accumulator, result and run_idx cleared; done, timeout and busy all 0. uo_out=8'h00.
- Start input:
  - ui_in[0] passes through a 2-flop synchroniser, then a rising-edge detect.
  - A start edge while busy is ignored.
- Return path:
  - Selected tap, or uio_in[0], feeds a 2-flop synchroniser to give ret_s.
  - Tap select is latched in IDLE on start.
- FSM states: IDLE, LAUNCH, WAIT, DONE.
- IDLE:
  - On a start edge: latch tap and avg mode, clear accumulator and run_idx, clear done and timeout, go to LAUNCH.
  - Moving to LAUNCH sets busy=1.
- LAUNCH (1 cycle): launch <= ~launch; cnt <= 0; go to WAIT.
- WAIT:
  - cnt increments by 1 per cycle, saturating at all-ones.
  - Match is ret_s==launch. On the first cycle of a match, the captured run value is cnt+1.
  - A zero-delay loop yields exactly 2. A return delayed by N whole cycles yields 2+N.
- After a match, single mode: result <= run value; go to DONE.
- After a match, avg mode:
  - accum <= accum + run value; accum is CNT_W+AVG_LOG2 bits wide.
  - If run_idx == 2^AVG_LOG2-1: result <= (accum+run)>>AVG_LOG2, truncating; go to DONE.
  - Otherwise run_idx++ and go to LAUNCH.
- Timeout: if cnt reaches MAX_COUNT-1 with no match, result <= all-ones (CNT_W bits), timeout <= 1, go to DONE. This aborts any remaining averaging runs.
- DONE:
  - busy=0, done=1. Result is held.
  - A start edge behaves as it does from IDLE.
- ena=0: FSM is forced to IDLE synchronously and busy is cleared. result, done and timeout hold.
- Readout, combinational mux on ui_in[5:4]:
  - 0: result[7:0]
  - 1: result[15:8]
  - 2: {busy, done, timeout, avg_latched, run_idx[3:0]}
  - 3: {6'b0, launch, ret_s}
- Reset asserted mid-run aborts immediately to the reset values.

Optional Feature:
- Macro: DELAY_METER_EXT_LOOP_EN.
- Defined:
  - uio_out[0]=launch and uio_oe=8'h01.
  - The return source is uio_in[0]; tap select is ignored.
  - The internal chain is not instantiated.
- Undefined:
  - The return source is the selected internal tap.
  - uio_out=8'h00, uio_oe=8'h00; uio_in is ignored.

Test Plan:
- EXT_LOOP_EN, bench ties uio_in[0]=uio_out[0] with zero delay; pulse start -> result 2, done=1, timeout=0; sel 0 reads 8'h02.
- EXT_LOOP_EN, bench delays the loop by 5 whole clk cycles -> result 7; sel 2 reads 8'h40.
- EXT_LOOP_EN, avg mode, AVG_LOG2=3, loop delay alternating 3 and 5 cycles across the 8 runs -> runs 5,7,... accumulate to 48, result 6; run_idx reaches 7.
- MAX_COUNT=100, loop held at 0 after the launch toggles to 1 -> done after 100 WAIT cycles; result 16'hFFFF, timeout=1; sel 2 reads 8'h60.
- Second start pulse during WAIT -> ignored, result unchanged. rst_n low mid-WAIT -> uo_out 8'h00, state IDLE, launch 0.
- No macro, zero-delay simulation chain, tap 2 -> result 2; uio_out=8'h00 and uio_oe=8'h00 throughout.
